// File: rtl/qnigma_pkg.sv
// rtl/qnigma_pkg.sv - shared TCP types, retransmit FSM states and timing constants
package qnigma_pkg;

    typedef enum logic [2:0] {
        tcp_closed,
        tcp_listen,
        tcp_syn_sent,
        tcp_syn_rcvd,
        tcp_connected,
        tcp_fin_wait,
        tcp_close_wait,
        tcp_last_ack
    } tcp_status_t;

    typedef struct packed {
        tcp_status_t status;
        logic [31:0] rem_ack;
    } tcb_t;

    typedef enum logic [1:0] {
        RTX_IDLE,
        RTX_ARMED,
        RTX_REQ,
        RTX_ABORT
    } rtx_state_t;

    localparam int TCP_RTO_TICKS     = 1_000_000;
    localparam int TCP_RTO_MAX_SHIFT = 6;
    localparam int TCP_RTX_TRIES     = 8;

endpackage

// File: rtl/qnigma_tcp_rto_timer.sv
// rtl/qnigma_tcp_rto_timer.sv - RTO timer with exponential backoff and retry counter
module qnigma_tcp_rto_timer
    import qnigma_pkg::*;
#(
    parameter int RTO_TICKS     = TCP_RTO_TICKS,
    parameter int RTO_MAX_SHIFT = TCP_RTO_MAX_SHIFT,
    parameter int RTX_TRIES     = TCP_RTX_TRIES
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    input  logic backoff,
    output logic expired,
    output logic exhausted
);

    localparam int TW = $clog2((RTO_TICKS << RTO_MAX_SHIFT) + 1);
    localparam int SW = (RTO_MAX_SHIFT > 0) ? $clog2(RTO_MAX_SHIFT + 1) : 1;
    localparam int NW = $clog2(RTX_TRIES + 1);

    logic [TW-1:0] r_timer;
    logic [SW-1:0] r_shift;
    logic [NW-1:0] r_tries;
    logic [TW-1:0] w_limit;

    // Current RTO is the base scaled by the backoff exponent; expiry is its last tick.
    assign w_limit   = TW'((RTO_TICKS << r_shift) - 1);
    assign expired   = (r_timer == w_limit);
    // Asserted when one more timeout would use up the allowed retries.
    assign exhausted = ((int'(r_tries) + 1) >= RTX_TRIES);

    // Timer only counts while running; any non-running cycle restarts it from zero.
    // Backoff widens the next RTO (saturating) and counts the timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer <= '0;
            r_shift <= '0;
            r_tries <= '0;
        end else begin
            if (run) begin
                r_timer <= r_timer + TW'(1);
            end else begin
                r_timer <= '0;
            end
            if (clr) begin
                r_shift <= '0;
                r_tries <= '0;
            end else if (backoff) begin
                if (int'(r_shift) < RTO_MAX_SHIFT) begin
                    r_shift <= r_shift + SW'(1);
                end
                if (int'(r_tries) < RTX_TRIES) begin
                    r_tries <= r_tries + NW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/qnigma_tcp_rtx_ctl.sv
// rtl/qnigma_tcp_rtx_ctl.sv - TCP retransmit controller (fast retransmit enabled by QNIGMA_TCP_FAST_RTX_EN)
module qnigma_tcp_rtx_ctl
    import qnigma_pkg::*;
#(
    parameter int RTO_TICKS     = TCP_RTO_TICKS,
    parameter int RTO_MAX_SHIFT = TCP_RTO_MAX_SHIFT,
    parameter int RTX_TRIES     = TCP_RTX_TRIES
) (
    input  logic        clk,
    input  logic        rst,
    input  tcb_t        tcb,
    input  logic [31:0] last_seq,
    input  logic        dup_det,
    input  logic [31:0] dup_ack,
    output logic        rtx_req,
    output logic [31:0] rtx_seq,
    output logic        rtx_fast,
    input  logic        rtx_ack,
    output logic        rtx_abort
);

    rtx_state_t  r_state;
    logic [31:0] r_prev_ack;
    logic [31:0] r_rtx_seq;
    logic        r_rtx_req;
    logic        r_rtx_abort;

    logic w_connected;
    logic w_out;
    logic w_ack_adv;
    logic w_armed_out;
    logic w_fast_hit;
    logic w_expired;
    logic w_exhausted;
    logic w_clr;
    logic w_run;
    logic w_backoff;

    assign w_connected = (tcb.status == tcp_connected);
    assign w_out       = w_connected && (last_seq != tcb.rem_ack);
    assign w_ack_adv   = (tcb.rem_ack != r_prev_ack);
    assign w_armed_out = (r_state == RTX_ARMED) && w_out;

`ifdef QNIGMA_TCP_FAST_RTX_EN
    logic [31:0] r_fast_seq;
    logic        r_fast_done;
    logic        r_rtx_fast;

    // A duplicate ACK already answered once is not retransmitted again.
    assign w_fast_hit = dup_det && !(r_fast_done && (r_fast_seq == dup_ack));
    assign rtx_fast   = r_rtx_fast;

    // Remember which duplicate ACK has been served, whether by a fast or a timeout request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fast_seq  <= '0;
            r_fast_done <= 1'b0;
            r_rtx_fast  <= 1'b0;
        end else if (r_state == RTX_IDLE) begin
            r_fast_done <= 1'b0;
        end else if (w_armed_out && !w_ack_adv && (w_expired || w_fast_hit)) begin
            if (dup_det) begin
                r_fast_seq  <= dup_ack;
                r_fast_done <= 1'b1;
            end
            r_rtx_fast <= !w_expired;
        end
    end
`else
    logic w_unused_fast;

    assign w_unused_fast = dup_det ^ (^dup_ack);
    assign w_fast_hit    = 1'b0;
    assign rtx_fast      = 1'b0;
`endif

    // Timer runs only in ARMED while nothing of higher priority happens this cycle.
    assign w_clr     = (r_state == RTX_IDLE) || (w_armed_out && w_ack_adv);
    assign w_backoff = w_armed_out && !w_ack_adv && w_expired;
    assign w_run     = w_armed_out && !w_ack_adv && !w_expired && !w_fast_hit;

    qnigma_tcp_rto_timer #(
        .RTO_TICKS     (RTO_TICKS),
        .RTO_MAX_SHIFT (RTO_MAX_SHIFT),
        .RTX_TRIES     (RTX_TRIES)
    ) u_rto_timer (
        .clk       (clk),
        .rst       (rst),
        .clr       (w_clr),
        .run       (w_run),
        .backoff   (w_backoff),
        .expired   (w_expired),
        .exhausted (w_exhausted)
    );

    assign rtx_req   = r_rtx_req;
    assign rtx_seq   = r_rtx_seq;
    assign rtx_abort = r_rtx_abort;

    // Request FSM: priority is disconnect > ACK advance > expiry > fast retransmit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= RTX_IDLE;
            r_prev_ack  <= '0;
            r_rtx_seq   <= '0;
            r_rtx_req   <= 1'b0;
            r_rtx_abort <= 1'b0;
        end else begin
            r_prev_ack  <= tcb.rem_ack;
            r_rtx_abort <= 1'b0;
            case (r_state)
                RTX_IDLE: begin
                    if (w_out) begin
                        r_state <= RTX_ARMED;
                    end
                end
                RTX_ARMED: begin
                    if (!w_out) begin
                        r_state <= RTX_IDLE;
                    end else if (!w_ack_adv) begin
                        if (w_expired) begin
                            if (w_exhausted) begin
                                r_state     <= RTX_ABORT;
                                r_rtx_abort <= 1'b1;
                            end else begin
                                r_state   <= RTX_REQ;
                                r_rtx_req <= 1'b1;
                                r_rtx_seq <= tcb.rem_ack;
                            end
                        end else if (w_fast_hit) begin
                            r_state   <= RTX_REQ;
                            r_rtx_req <= 1'b1;
                            r_rtx_seq <= dup_ack;
                        end
                    end
                end
                RTX_REQ: begin
                    if (!w_connected) begin
                        r_state   <= RTX_IDLE;
                        r_rtx_req <= 1'b0;
                    end else if (rtx_ack) begin
                        r_state   <= RTX_ARMED;
                        r_rtx_req <= 1'b0;
                    end
                end
                RTX_ABORT: begin
                    if (!w_connected) begin
                        r_state <= RTX_IDLE;
                    end
                end
                default: begin
                    r_state   <= RTX_IDLE;
                    r_rtx_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qnigma_tcp_rtx_ctl.sv
// tb/tb_qnigma_tcp_rtx_ctl.sv - self-checking bench for qnigma_tcp_rtx_ctl
module tb_qnigma_tcp_rtx_ctl;
    import qnigma_pkg::*;

    localparam int RTO   = 100;
    localparam int MAXS  = 2;
    localparam int TRIES = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    tcb_t        tcb;
    logic [31:0] last_seq;
    logic        dup_det;
    logic [31:0] dup_ack;
    logic        rtx_req;
    logic [31:0] rtx_seq;
    logic        rtx_fast;
    logic        rtx_ack;
    logic        rtx_abort;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    qnigma_tcp_rtx_ctl #(
        .RTO_TICKS     (RTO),
        .RTO_MAX_SHIFT (MAXS),
        .RTX_TRIES     (TRIES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tcb       (tcb),
        .last_seq  (last_seq),
        .dup_det   (dup_det),
        .dup_ack   (dup_ack),
        .rtx_req   (rtx_req),
        .rtx_seq   (rtx_seq),
        .rtx_fast  (rtx_fast),
        .rtx_ack   (rtx_ack),
        .rtx_abort (rtx_abort)
    );

    // Reference: k-th consecutive timeout waits base RTO doubled k times, capped at MAXS.
    function automatic int rto_gap(input int k);
        return RTO << ((k < MAXS) ? k : MAXS);
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Edges until rtx_req or rtx_abort is seen, or -1 if the budget runs out.
    task automatic wait_event(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (rtx_req || rtx_abort) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic go_idle();
        tcb.status = tcp_closed;
        rtx_ack    = 1'b0;
        dup_det    = 1'b0;
        step(3);
    endtask

    // Opens a connection with outstanding data; the next posedge is ARMED entry edge 1.
    task automatic connect(output logic [31:0] una);
        last_seq    = $urandom;
        una         = last_seq - 32'($urandom_range(2, 5000));
        tcb.rem_ack = una;
        step(2);
        tcb.status = tcp_connected;
    endtask

    task automatic ack_req();
        rtx_ack = 1'b1;
        step(1);
        rtx_ack = 1'b0;
    endtask

    task automatic test_reset();
        tcb.status  = tcp_closed;
        tcb.rem_ack = '0;
        last_seq    = '0;
        dup_det     = 1'b0;
        dup_ack     = '0;
        rtx_ack     = 1'b0;
        rst         = 1'b1;
        step(2);
        checks++; if (rtx_req !== 1'b0) $display("FAIL reset_req: got %0b want 0", rtx_req); else passed++;
        checks++; if (rtx_seq !== 32'd0) $display("FAIL reset_seq: got %0h want 0", rtx_seq); else passed++;
        checks++; if (rtx_fast !== 1'b0) $display("FAIL reset_fast: got %0b want 0", rtx_fast); else passed++;
        checks++; if (rtx_abort !== 1'b0) $display("FAIL reset_abort: got %0b want 0", rtx_abort); else passed++;
        rst = 1'b0;
        step(2);
    endtask

    task automatic test_basic_timeout();
        logic [31:0] una;
        int n;
        int hold;
        go_idle();
        connect(una);
        wait_event(1000, n);
        checks++; if (n != RTO + 1) $display("FAIL basic_latency: got %0d want %0d", n, RTO + 1); else passed++;
        checks++; if (rtx_req !== 1'b1) $display("FAIL basic_req: got %0b want 1", rtx_req); else passed++;
        checks++; if (rtx_seq !== una) $display("FAIL basic_seq: got %0h want %0h", rtx_seq, una); else passed++;
        checks++; if (rtx_fast !== 1'b0) $display("FAIL basic_fast: got %0b want 0", rtx_fast); else passed++;
        hold = $urandom_range(5, 7);
        for (int i = 0; i < hold; i++) begin
            step(1);
            checks++; if (rtx_req !== 1'b1 || rtx_seq !== una)
                $display("FAIL basic_hold: got req=%0b seq=%0h want req=1 seq=%0h", rtx_req, rtx_seq, una);
            else passed++;
        end
        ack_req();
        checks++; if (rtx_req !== 1'b0) $display("FAIL basic_drop: got %0b want 0", rtx_req); else passed++;
    endtask

    task automatic test_backoff_abort();
        logic [31:0] una;
        int n;
        int exp_n;
        go_idle();
        connect(una);
        for (int k = 0; k < TRIES; k++) begin
            wait_event(2000, n);
            exp_n = rto_gap(k) + ((k == 0) ? 1 : 0);
            checks++; if (n != exp_n) $display("FAIL backoff_gap%0d: got %0d want %0d", k, n, exp_n); else passed++;
            if (k + 1 < TRIES) begin
                checks++; if (rtx_req !== 1'b1 || rtx_abort !== 1'b0 || rtx_seq !== una)
                    $display("FAIL backoff_req%0d: got req=%0b abort=%0b seq=%0h want 1 0 %0h",
                             k, rtx_req, rtx_abort, rtx_seq, una);
                else passed++;
                step($urandom_range(0, 3));
                ack_req();
                checks++; if (rtx_req !== 1'b0) $display("FAIL backoff_drop%0d: got %0b want 0", k, rtx_req); else passed++;
            end else begin
                checks++; if (rtx_abort !== 1'b1 || rtx_req !== 1'b0)
                    $display("FAIL abort_entry: got abort=%0b req=%0b want 1 0", rtx_abort, rtx_req);
                else passed++;
                step(1);
                checks++; if (rtx_abort !== 1'b0) $display("FAIL abort_pulse: got %0b want 0", rtx_abort); else passed++;
                wait_event(300, n);
                checks++; if (n != -1) $display("FAIL abort_quiet: got event at %0d want none", n); else passed++;
            end
        end
        go_idle();
    endtask

    task automatic test_ack_advance();
        logic [31:0] una;
        logic [31:0] adv;
        int n;
        go_idle();
        connect(una);
        step(RTO);
        checks++; if (rtx_req !== 1'b0) $display("FAIL adv_early: got %0b want 0", rtx_req); else passed++;
        adv = una + 32'($urandom_range(1, 32'(last_seq - una) - 1));
        tcb.rem_ack = adv;
        wait_event(1000, n);
        checks++; if (n != RTO + 1) $display("FAIL adv_restart: got %0d want %0d", n, RTO + 1); else passed++;
        checks++; if (rtx_seq !== adv) $display("FAIL adv_seq: got %0h want %0h", rtx_seq, adv); else passed++;
        ack_req();
        step(150);
        checks++; if (rtx_req !== 1'b0) $display("FAIL adv_mid: got %0b want 0", rtx_req); else passed++;
        if (adv + 1 != last_seq) tcb.rem_ack = adv + 1;
        else tcb.rem_ack = adv - 1;
        wait_event(1000, n);
        checks++; if (n != RTO + 1) $display("FAIL adv_shift_clear: got %0d want %0d", n, RTO + 1); else passed++;
        ack_req();
        tcb.rem_ack = last_seq;
        wait_event(1000, n);
        checks++; if (n != -1) $display("FAIL adv_all_acked: got event at %0d want none", n); else passed++;
        go_idle();
    endtask

`ifdef QNIGMA_TCP_FAST_RTX_EN
    task automatic test_fast();
        logic [31:0] una;
        logic [31:0] d1;
        logic [31:0] d2;
        int n;
        go_idle();
        connect(una);
        step(10);
        d1      = $urandom;
        dup_ack = d1;
        dup_det = 1'b1;
        wait_event(5, n);
        checks++; if (n != 1) $display("FAIL fast_latency: got %0d want 1", n); else passed++;
        checks++; if (rtx_seq !== d1 || rtx_fast !== 1'b1)
            $display("FAIL fast_req: got seq=%0h fast=%0b want %0h 1", rtx_seq, rtx_fast, d1);
        else passed++;
        step($urandom_range(0, 2));
        ack_req();
        wait_event(40, n);
        checks++; if (n != -1) $display("FAIL fast_repeat: got event at %0d want none", n); else passed++;
        d2      = d1 + 32'($urandom_range(1, 1000));
        dup_ack = d2;
        wait_event(5, n);
        checks++; if (n != 1 || rtx_seq !== d2 || rtx_fast !== 1'b1)
            $display("FAIL fast_new: got n=%0d seq=%0h fast=%0b want 1 %0h 1", n, rtx_seq, rtx_fast, d2);
        else passed++;
        ack_req();
        dup_det = 1'b0;
        go_idle();
    endtask
`else
    task automatic test_fast_disabled();
        logic [31:0] una;
        int n;
        go_idle();
        connect(una);
        step(10);
        dup_ack = $urandom;
        dup_det = 1'b1;
        wait_event(50, n);
        checks++; if (n != -1) $display("FAIL nofast_ignored: got event at %0d want none", n); else passed++;
        dup_det = 1'b0;
        wait_event(200, n);
        checks++; if (n != RTO + 1 - 60) $display("FAIL nofast_timeout: got %0d want %0d", n, RTO + 1 - 60); else passed++;
        checks++; if (rtx_seq !== una || rtx_fast !== 1'b0)
            $display("FAIL nofast_req: got seq=%0h fast=%0b want %0h 0", rtx_seq, rtx_fast, una);
        else passed++;
        ack_req();
        go_idle();
    endtask
`endif

    task automatic test_simultaneous();
        logic [31:0] una;
        int n;
        go_idle();
        connect(una);
        step(RTO);
        dup_ack = $urandom;
        dup_det = 1'b1;
        wait_event(10, n);
        checks++; if (n != 1 || rtx_fast !== 1'b0 || rtx_seq !== una)
            $display("FAIL simul_req: got n=%0d fast=%0b seq=%0h want 1 0 %0h", n, rtx_fast, rtx_seq, una);
        else passed++;
        ack_req();
        wait_event(60, n);
        checks++; if (n != -1) $display("FAIL simul_no_fast: got event at %0d want none", n); else passed++;
        dup_det = 1'b0;
        wait_event(1000, n);
        checks++; if (n != rto_gap(1) - 60) $display("FAIL simul_next: got %0d want %0d", n, rto_gap(1) - 60); else passed++;
        tcb.status = tcp_closed;
        step(1);
        checks++; if (rtx_req !== 1'b0) $display("FAIL withdraw: got %0b want 0", rtx_req); else passed++;
        go_idle();
    endtask

    task automatic test_reset_mid_req();
        logic [31:0] una;
        int n;
        go_idle();
        connect(una);
        wait_event(1000, n);
        checks++; if (n != RTO + 1 || rtx_req !== 1'b1) $display("FAIL rstreq_pre: got n=%0d req=%0b want %0d 1", n, rtx_req, RTO + 1); else passed++;
        #2 rst = 1'b1;
        #1;
        checks++; if (rtx_req !== 1'b0 || rtx_seq !== 32'd0 || rtx_fast !== 1'b0 || rtx_abort !== 1'b0)
            $display("FAIL rst_async: got req=%0b seq=%0h fast=%0b abort=%0b want all 0", rtx_req, rtx_seq, rtx_fast, rtx_abort);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        wait_event(1000, n);
        checks++; if (n != RTO + 1) $display("FAIL rst_rearm: got %0d want %0d", n, RTO + 1); else passed++;
        ack_req();
        go_idle();
    endtask

    initial begin
        test_reset();
        test_basic_timeout();
        test_backoff_abort();
        test_ack_advance();
`ifdef QNIGMA_TCP_FAST_RTX_EN
        test_fast();
`else
        test_fast_disabled();
`endif
        test_simultaneous();
        test_reset_mid_req();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
